// File: rtl/cr16_run_ctrl_if.sv
// Control/status bundle between board-level run controls and cr16_run_ctrl.
// The master side drives the requests; the slave side is the controller.
interface cr16_run_ctrl_if;
    logic        I_RUN;
    logic        I_STEP;
    logic        I_HALT;
    logic        I_CLEAR;
    logic [15:0] I_PC;
    logic [15:0] I_BREAK_PC;
    logic        I_BREAK_VALID;
    logic        O_CPU_ENABLE;
    logic [2:0]  O_STATE;
    logic        O_HALTED;
    logic [1:0]  O_HALT_CAUSE;
    logic [31:0] O_CYCLE_COUNT;

    modport slave (
        input  I_RUN, I_STEP, I_HALT, I_CLEAR, I_PC, I_BREAK_PC, I_BREAK_VALID,
        output O_CPU_ENABLE, O_STATE, O_HALTED, O_HALT_CAUSE, O_CYCLE_COUNT
    );

    modport master (
        output I_RUN, I_STEP, I_HALT, I_CLEAR, I_PC, I_BREAK_PC, I_BREAK_VALID,
        input  O_CPU_ENABLE, O_STATE, O_HALTED, O_HALT_CAUSE, O_CYCLE_COUNT
    );
endinterface

// File: rtl/cr16_run_ctrl.sv
// CR16 run controller: BRAM warm-up, then gates the core enable for run/step/breakpoint.
// Define CR16_RUN_CTRL_MAX_PC_EN to add the PC > P_MAX_PC stop condition (halt cause 2).
//
//  state   | meaning
//  WARMUP  | core held off after reset while BRAM outputs settle
//  IDLE    | core stopped, waiting for run or a step edge
//  RUN     | free-run until halt, stop condition or run dropped
//  STEP    | exactly one enabled cycle
//  HALT    | stopped on breakpoint/max-PC, only I_CLEAR leaves
module cr16_run_ctrl #(
    parameter logic [15:0] P_WARMUP_CYCLES = 16'd1,
    parameter logic [15:0] P_MAX_PC        = 16'd20
) (
    input  logic I_CLK,
    input  logic I_RESET,
    cr16_run_ctrl_if.slave io_ctl
);

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [15:0] L_WARM_LAST =
        (P_WARMUP_CYCLES == 16'd0) ? 16'd0 : P_WARMUP_CYCLES - 16'd1;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_warm_cnt;
    logic        r_step_q;
    logic [1:0]  r_cause;
    logic [31:0] r_count;
    logic        w_step_pulse;
    logic        w_bp_hit;
    logic        w_max_hit;
    logic        w_stop;
    logic        w_enable;

    assign w_step_pulse = io_ctl.I_STEP & ~r_step_q;
    assign w_bp_hit     = io_ctl.I_BREAK_VALID && (io_ctl.I_PC == io_ctl.I_BREAK_PC);

`ifdef CR16_RUN_CTRL_MAX_PC_EN
    assign w_max_hit = (io_ctl.I_PC > P_MAX_PC);
`else
    logic w_unused_max_pc;
    assign w_max_hit       = 1'b0;
    assign w_unused_max_pc = ^P_MAX_PC;
`endif

    assign w_stop = w_bp_hit | w_max_hit;

    // Enable is combinational on stop so the core never executes at a stop PC.
    always_comb begin
        w_next   = r_state;
        w_enable = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (r_warm_cnt == L_WARM_LAST) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (!io_ctl.I_HALT) begin
                    if (io_ctl.I_RUN)      w_next = ST_RUN;
                    else if (w_step_pulse) w_next = ST_STEP;
                end
            end
            ST_RUN: begin
                w_enable = !w_stop;
                if (io_ctl.I_HALT)      w_next = ST_IDLE;
                else if (w_stop)        w_next = ST_HALT;
                else if (!io_ctl.I_RUN) w_next = ST_IDLE;
            end
            ST_STEP: begin
                w_enable = !w_stop;
                w_next   = w_stop ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
                if (io_ctl.I_CLEAR) w_next = ST_IDLE;
            end
            default: w_next = ST_WARMUP;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= 16'd0;
            r_step_q   <= 1'b0;
            r_cause    <= 2'd0;
            r_count    <= 32'd0;
        end else begin
            r_state  <= w_next;
            r_step_q <= io_ctl.I_STEP;
            if (r_state == ST_WARMUP) r_warm_cnt <= r_warm_cnt + 16'd1;
            if (io_ctl.I_CLEAR)
                r_count <= 32'd0;
            else if (w_enable && (r_count != 32'hFFFF_FFFF))
                r_count <= r_count + 32'd1;
            // Breakpoint outranks max-PC when both hold on the halting cycle.
            if ((w_next == ST_HALT) && (r_state != ST_HALT))
                r_cause <= w_bp_hit ? 2'd1 : 2'd2;
            else if ((r_state == ST_HALT) && io_ctl.I_CLEAR)
                r_cause <= 2'd0;
        end
    end

    assign io_ctl.O_CPU_ENABLE  = w_enable;
    assign io_ctl.O_STATE       = r_state;
    assign io_ctl.O_HALTED      = (r_state == ST_HALT);
    assign io_ctl.O_HALT_CAUSE  = r_cause;
    assign io_ctl.O_CYCLE_COUNT = r_count;

endmodule
